// File: rtl/core2axi4l_pkg.sv
// -----------------------------------------------------------------------------
// core2axi4l_pkg
// Shared types for the multi-outstanding core-to-AXI4-Lite bridge.
//   resp_t        : AXI4-Lite response encoding
//   txn_t         : per-transaction record kept in the order FIFO
//   PROT_DEFAULT  : default value driven on awprot/arprot
//   resp_is_err() : true for SLVERR/DECERR responses
// -----------------------------------------------------------------------------
package core2axi4l_pkg;

    typedef enum logic [1:0] {
        RESP_OKAY   = 2'b00,
        RESP_EXOKAY = 2'b01,
        RESP_SLVERR = 2'b10,
        RESP_DECERR = 2'b11
    } resp_t;

    // Only the direction is needed to steer bready/rready for the head entry.
    typedef struct packed {
        logic we;
    } txn_t;

    localparam logic [2:0] PROT_DEFAULT = 3'b000;

    function automatic logic resp_is_err(input resp_t resp);
        return (resp == RESP_SLVERR) || (resp == RESP_DECERR);
    endfunction

endpackage

// File: rtl/core2axi4l_order_fifo.sv
// -----------------------------------------------------------------------------
// core2axi4l_order_fifo
// Small synchronous FIFO remembering the issue order of accepted transactions.
//   clk, rst : clock, asynchronous active-high reset
//   push/din : write an entry (ignored when full unless a pop happens too)
//   pop/dout : drop the head entry; dout is the current head (combinational)
//   full, empty, count : occupancy status
// DEPTH must be a power of two. Pointers carry one extra bit so that
// wr_ptr - rd_ptr gives the occupancy directly and full/empty are distinct.
// -----------------------------------------------------------------------------
module core2axi4l_order_fifo #(
    parameter int unsigned WIDTH = 1,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         din,
    input  logic                     pop,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned IDX_WIDTH = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned PTR_WIDTH = $clog2(DEPTH) + 1;

    logic [PTR_WIDTH-1:0]          wr_ptr_reg;
    logic [PTR_WIDTH-1:0]          rd_ptr_reg;
    logic [IDX_WIDTH-1:0]          wr_idx;
    logic [IDX_WIDTH-1:0]          rd_idx;
    logic [DEPTH-1:0][WIDTH-1:0]   mem_q;
    logic                          push_ok;
    logic                          pop_ok;

    assign count   = wr_ptr_reg - rd_ptr_reg;
    assign full    = (count == PTR_WIDTH'(DEPTH));
    assign empty   = (count == '0);

    // A push while full is legal only when the head leaves in the same cycle.
    assign pop_ok  = pop && !empty;
    assign push_ok = push && (!full || pop_ok);

    generate
        if (DEPTH > 1) begin : g_idx
            assign wr_idx = wr_ptr_reg[IDX_WIDTH-1:0];
            assign rd_idx = rd_ptr_reg[IDX_WIDTH-1:0];
        end else begin : g_idx_single
            assign wr_idx = '0;
            assign rd_idx = '0;
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_entry
            logic [WIDTH-1:0] entry_reg;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    entry_reg <= '0;
                end else if (push_ok && (wr_idx == IDX_WIDTH'(gi))) begin
                    entry_reg <= din;
                end
            end

            assign mem_q[gi] = entry_reg;
        end
    endgenerate

    assign dout = mem_q[rd_idx];

endmodule

// File: rtl/core2axi4l_mo.sv
// -----------------------------------------------------------------------------
// core2axi4l_mo
// Core (req/gnt/rvalid) to AXI4-Lite master bridge with up to MAX_OUTSTANDING
// transactions in flight; responses go back to the core in issue order.
// Ports:
//   clk, rst                 : clock, asynchronous active-high reset
//   core_req/gnt/we/be/addr/wdata : core request side (gnt is combinational)
//   core_rvalid/rdata/err    : registered one-cycle response to the core
//   axi_aw*, axi_w*, axi_b*  : AXI4-Lite write address, write data, write response
//   axi_ar*, axi_r*          : AXI4-Lite read address, read data
//   outstanding              : accepted-but-unanswered transaction count
// -----------------------------------------------------------------------------
module core2axi4l_mo
    import core2axi4l_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH      = 32,
    parameter int unsigned DATA_WIDTH      = 32,
    parameter int unsigned MAX_OUTSTANDING = 4,
    parameter logic [2:0]  PROT            = PROT_DEFAULT
) (
    input  logic                            clk,
    input  logic                            rst,
    // core side
    input  logic                            core_req,
    output logic                            core_gnt,
    input  logic                            core_we,
    input  logic [DATA_WIDTH/8-1:0]         core_be,
    input  logic [ADDR_WIDTH-1:0]           core_addr,
    input  logic [DATA_WIDTH-1:0]           core_wdata,
    output logic                            core_rvalid,
    output logic [DATA_WIDTH-1:0]           core_rdata,
    output logic                            core_err,
    // AXI4-Lite write address
    output logic                            axi_awvalid,
    input  logic                            axi_awready,
    output logic [ADDR_WIDTH-1:0]           axi_awaddr,
    output logic [2:0]                      axi_awprot,
    // AXI4-Lite write data
    output logic                            axi_wvalid,
    input  logic                            axi_wready,
    output logic [DATA_WIDTH-1:0]           axi_wdata,
    output logic [DATA_WIDTH/8-1:0]         axi_wstrb,
    // AXI4-Lite write response
    input  logic                            axi_bvalid,
    output logic                            axi_bready,
    input  logic [1:0]                      axi_bresp,
    // AXI4-Lite read address
    output logic                            axi_arvalid,
    input  logic                            axi_arready,
    output logic [ADDR_WIDTH-1:0]           axi_araddr,
    output logic [2:0]                      axi_arprot,
    // AXI4-Lite read data
    input  logic                            axi_rvalid,
    output logic                            axi_rready,
    input  logic [DATA_WIDTH-1:0]           axi_rdata,
    input  logic [1:0]                      axi_rresp,
    // status
    output logic [$clog2(MAX_OUTSTANDING):0] outstanding
);

    localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;

    // holding registers
    logic                   awvalid_reg;
    logic [ADDR_WIDTH-1:0]  awaddr_reg;
    logic                   wvalid_reg;
    logic [DATA_WIDTH-1:0]  wdata_reg;
    logic [STRB_WIDTH-1:0]  wstrb_reg;
    logic                   arvalid_reg;
    logic [ADDR_WIDTH-1:0]  araddr_reg;

    // response register
    logic                   rvalid_reg;
    logic                   rvalid_next;
    logic                   err_reg;
    logic                   err_next;
    logic [DATA_WIDTH-1:0]  rdata_reg;
    logic [DATA_WIDTH-1:0]  rdata_next;

    // order FIFO
    txn_t                   push_txn;
    txn_t                   head_txn;
    logic [$bits(txn_t)-1:0] head_bits;
    logic                   fifo_full;
    logic                   fifo_empty;

    logic                   aw_free;
    logic                   w_free;
    logic                   ar_free;
    logic                   slot_free;
    logic                   room;
    logic                   push;
    logic                   pop;
    logic                   b_hs;
    logic                   r_hs;

    // A holding slot counts as free in the cycle its handshake completes, so
    // a new request can be loaded behind it and reads stream at one per cycle.
    assign aw_free   = !awvalid_reg || axi_awready;
    assign w_free    = !wvalid_reg  || axi_wready;
    assign ar_free   = !arvalid_reg || axi_arready;
    assign slot_free = core_we ? (aw_free && w_free) : ar_free;

    // Full FIFO still has room if its head is answered this cycle.
    assign room      = !fifo_full || pop;
    assign core_gnt  = core_req && room && slot_free;
    assign push      = core_req && core_gnt;

    // Only the response type matching the oldest transaction is accepted.
    assign axi_bready = !fifo_empty &&  head_txn.we;
    assign axi_rready = !fifo_empty && !head_txn.we;
    assign b_hs       = axi_bvalid && axi_bready;
    assign r_hs       = axi_rvalid && axi_rready;
    assign pop        = b_hs || r_hs;

    assign push_txn   = '{we: core_we};
    assign head_txn   = txn_t'(head_bits);

    core2axi4l_order_fifo #(
        .WIDTH ($bits(txn_t)),
        .DEPTH (MAX_OUTSTANDING)
    ) u_order_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .din   (push_txn),
        .pop   (pop),
        .dout  (head_bits),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (outstanding)
    );

    // Write address channel: a new load takes priority over clearing, which
    // only happens when the slot was freed by a handshake this cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            awvalid_reg <= 1'b0;
            awaddr_reg  <= '0;
        end else if (push && core_we) begin
            awvalid_reg <= 1'b1;
            awaddr_reg  <= core_addr;
        end else if (axi_awready) begin
            awvalid_reg <= 1'b0;
        end
    end

    // Write data channel, independent of the address channel.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wvalid_reg <= 1'b0;
            wdata_reg  <= '0;
            wstrb_reg  <= '0;
        end else if (push && core_we) begin
            wvalid_reg <= 1'b1;
            wdata_reg  <= core_wdata;
            wstrb_reg  <= core_be;
        end else if (axi_wready) begin
            wvalid_reg <= 1'b0;
        end
    end

    // Read address channel.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            arvalid_reg <= 1'b0;
            araddr_reg  <= '0;
        end else if (push && !core_we) begin
            arvalid_reg <= 1'b1;
            araddr_reg  <= core_addr;
        end else if (axi_arready) begin
            arvalid_reg <= 1'b0;
        end
    end

    // bready and rready are never high together, so at most one of b_hs and
    // r_hs fires. Data/err hold their last value between pulses.
    always_comb begin
        rvalid_next = b_hs || r_hs;
        err_next    = err_reg;
        rdata_next  = rdata_reg;
        if (b_hs) begin
            err_next   = resp_is_err(resp_t'(axi_bresp));
            rdata_next = '0;
        end else if (r_hs) begin
            err_next   = resp_is_err(resp_t'(axi_rresp));
            rdata_next = axi_rdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rvalid_reg <= 1'b0;
            err_reg    <= 1'b0;
            rdata_reg  <= '0;
        end else begin
            rvalid_reg <= rvalid_next;
            err_reg    <= err_next;
            rdata_reg  <= rdata_next;
        end
    end

    assign axi_awvalid = awvalid_reg;
    assign axi_awaddr  = awaddr_reg;
    assign axi_awprot  = PROT;
    assign axi_wvalid  = wvalid_reg;
    assign axi_wdata   = wdata_reg;
    assign axi_wstrb   = wstrb_reg;
    assign axi_arvalid = arvalid_reg;
    assign axi_araddr  = araddr_reg;
    assign axi_arprot  = PROT;

    assign core_rvalid = rvalid_reg;
    assign core_rdata  = rdata_reg;
    assign core_err    = err_reg;

endmodule

// File: tb/tb_core2axi4l_mo.sv
// -----------------------------------------------------------------------------
// tb_core2axi4l_mo
// Directed bench for core2axi4l_mo with default parameters (32/32/4).
// Inputs change 1 time unit after the rising edge; outputs are checked a
// further unit later, well away from the next edge.
// -----------------------------------------------------------------------------
module tb_core2axi4l_mo;

    logic        clk;
    logic        rst;
    logic        core_req;
    logic        core_gnt;
    logic        core_we;
    logic [3:0]  core_be;
    logic [31:0] core_addr;
    logic [31:0] core_wdata;
    logic        core_rvalid;
    logic [31:0] core_rdata;
    logic        core_err;
    logic        axi_awvalid;
    logic        axi_awready;
    logic [31:0] axi_awaddr;
    logic [2:0]  axi_awprot;
    logic        axi_wvalid;
    logic        axi_wready;
    logic [31:0] axi_wdata;
    logic [3:0]  axi_wstrb;
    logic        axi_bvalid;
    logic        axi_bready;
    logic [1:0]  axi_bresp;
    logic        axi_arvalid;
    logic        axi_arready;
    logic [31:0] axi_araddr;
    logic [2:0]  axi_arprot;
    logic        axi_rvalid;
    logic        axi_rready;
    logic [31:0] axi_rdata;
    logic [1:0]  axi_rresp;
    logic [2:0]  outstanding;

    int total = 0;
    int bad = 0;
    int rvalid_pulses = 0;

    core2axi4l_mo dut (
        .clk         (clk),
        .rst         (rst),
        .core_req    (core_req),
        .core_gnt    (core_gnt),
        .core_we     (core_we),
        .core_be     (core_be),
        .core_addr   (core_addr),
        .core_wdata  (core_wdata),
        .core_rvalid (core_rvalid),
        .core_rdata  (core_rdata),
        .core_err    (core_err),
        .axi_awvalid (axi_awvalid),
        .axi_awready (axi_awready),
        .axi_awaddr  (axi_awaddr),
        .axi_awprot  (axi_awprot),
        .axi_wvalid  (axi_wvalid),
        .axi_wready  (axi_wready),
        .axi_wdata   (axi_wdata),
        .axi_wstrb   (axi_wstrb),
        .axi_bvalid  (axi_bvalid),
        .axi_bready  (axi_bready),
        .axi_bresp   (axi_bresp),
        .axi_arvalid (axi_arvalid),
        .axi_arready (axi_arready),
        .axi_araddr  (axi_araddr),
        .axi_arprot  (axi_arprot),
        .axi_rvalid  (axi_rvalid),
        .axi_rready  (axi_rready),
        .axi_rdata   (axi_rdata),
        .axi_rresp   (axi_rresp),
        .outstanding (outstanding)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Every core response pulse lasts exactly one cycle, so one sample per
    // cycle counts each pulse once.
    always @(negedge clk) begin
        if (core_rvalid === 1'b1) begin
            rvalid_pulses++;
        end
    end

    // Handshake stability: a pending valid stays up with its payload frozen.
    a_aw_stable: assert property (@(posedge clk) disable iff (rst)
        (axi_awvalid && !axi_awready) |=> (axi_awvalid && $stable(axi_awaddr) && $stable(axi_awprot)))
        else begin bad++; $display("FAIL aw_stable: awvalid=%b awaddr=%h", axi_awvalid, axi_awaddr); end
    a_w_stable: assert property (@(posedge clk) disable iff (rst)
        (axi_wvalid && !axi_wready) |=> (axi_wvalid && $stable(axi_wdata) && $stable(axi_wstrb)))
        else begin bad++; $display("FAIL w_stable: wvalid=%b wdata=%h", axi_wvalid, axi_wdata); end
    a_ar_stable: assert property (@(posedge clk) disable iff (rst)
        (axi_arvalid && !axi_arready) |=> (axi_arvalid && $stable(axi_araddr) && $stable(axi_arprot)))
        else begin bad++; $display("FAIL ar_stable: arvalid=%b araddr=%h", axi_arvalid, axi_araddr); end
    a_ready_excl: assert property (@(posedge clk) disable iff (rst) !(axi_bready && axi_rready))
        else begin bad++; $display("FAIL ready_excl: bready=%b rready=%b want not both", axi_bready, axi_rready); end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        total++; if (core_gnt !== 1'b0)    begin bad++; $display("FAIL rst_gnt: got %b want 0", core_gnt); end
        total++; if (core_rvalid !== 1'b0) begin bad++; $display("FAIL rst_rvalid: got %b want 0", core_rvalid); end
        total++; if (core_err !== 1'b0)    begin bad++; $display("FAIL rst_err: got %b want 0", core_err); end
        total++; if (core_rdata !== 32'h0) begin bad++; $display("FAIL rst_rdata: got %h want 0", core_rdata); end
        total++; if (axi_awvalid !== 1'b0) begin bad++; $display("FAIL rst_awvalid: got %b want 0", axi_awvalid); end
        total++; if (axi_wvalid !== 1'b0)  begin bad++; $display("FAIL rst_wvalid: got %b want 0", axi_wvalid); end
        total++; if (axi_arvalid !== 1'b0) begin bad++; $display("FAIL rst_arvalid: got %b want 0", axi_arvalid); end
        total++; if (axi_bready !== 1'b0)  begin bad++; $display("FAIL rst_bready: got %b want 0", axi_bready); end
        total++; if (axi_rready !== 1'b0)  begin bad++; $display("FAIL rst_rready: got %b want 0", axi_rready); end
        total++; if (outstanding !== 3'd0) begin bad++; $display("FAIL rst_count: got %0d want 0", outstanding); end
        rst = 1'b0;
        tick();
        $display("txn reset released");
    endtask

    task automatic test_single_write();
        axi_awready = 1'b1;
        axi_wready  = 1'b1;
        core_req    = 1'b1;
        core_we     = 1'b1;
        core_addr   = 32'h0000_1000;
        core_wdata  = 32'hDEAD_BEEF;
        core_be     = 4'hF;
        #1;
        total++; if (core_gnt !== 1'b1) begin bad++; $display("FAIL wr_gnt: got %b want 1", core_gnt); end
        tick();
        core_req = 1'b0;
        total++; if (axi_awvalid !== 1'b1)        begin bad++; $display("FAIL wr_awvalid: got %b want 1", axi_awvalid); end
        total++; if (axi_awaddr !== 32'h1000)     begin bad++; $display("FAIL wr_awaddr: got %h want 00001000", axi_awaddr); end
        total++; if (axi_awprot !== 3'b000)       begin bad++; $display("FAIL wr_awprot: got %b want 000", axi_awprot); end
        total++; if (axi_wvalid !== 1'b1)         begin bad++; $display("FAIL wr_wvalid: got %b want 1", axi_wvalid); end
        total++; if (axi_wdata !== 32'hDEADBEEF)  begin bad++; $display("FAIL wr_wdata: got %h want deadbeef", axi_wdata); end
        total++; if (axi_wstrb !== 4'hF)          begin bad++; $display("FAIL wr_wstrb: got %h want f", axi_wstrb); end
        total++; if (axi_bready !== 1'b1)         begin bad++; $display("FAIL wr_bready: got %b want 1", axi_bready); end
        total++; if (outstanding !== 3'd1)        begin bad++; $display("FAIL wr_count: got %0d want 1", outstanding); end
        tick();
        total++; if (axi_awvalid !== 1'b0) begin bad++; $display("FAIL wr_awdrop: got %b want 0", axi_awvalid); end
        total++; if (axi_wvalid !== 1'b0)  begin bad++; $display("FAIL wr_wdrop: got %b want 0", axi_wvalid); end
        axi_bvalid = 1'b1;
        axi_bresp  = 2'b00;
        tick();
        axi_bvalid = 1'b0;
        total++; if (core_rvalid !== 1'b1)  begin bad++; $display("FAIL wr_rvalid: got %b want 1", core_rvalid); end
        total++; if (core_err !== 1'b0)     begin bad++; $display("FAIL wr_err: got %b want 0", core_err); end
        total++; if (core_rdata !== 32'h0)  begin bad++; $display("FAIL wr_rdata: got %h want 0", core_rdata); end
        tick();
        total++; if (core_rvalid !== 1'b0)  begin bad++; $display("FAIL wr_rvalid_pulse: got %b want 0", core_rvalid); end
        total++; if (axi_bready !== 1'b0)   begin bad++; $display("FAIL wr_bready_idle: got %b want 0", axi_bready); end
        axi_awready = 1'b0;
        axi_wready  = 1'b0;
        $display("txn write addr=00001000 data=deadbeef");
    endtask

    task automatic test_single_read();
        axi_arready = 1'b1;
        core_req    = 1'b1;
        core_we     = 1'b0;
        core_addr   = 32'h0000_2004;
        #1;
        total++; if (core_gnt !== 1'b1) begin bad++; $display("FAIL rd_gnt: got %b want 1", core_gnt); end
        tick();
        core_req = 1'b0;
        total++; if (axi_arvalid !== 1'b1)    begin bad++; $display("FAIL rd_arvalid: got %b want 1", axi_arvalid); end
        total++; if (axi_araddr !== 32'h2004) begin bad++; $display("FAIL rd_araddr: got %h want 00002004", axi_araddr); end
        total++; if (axi_rready !== 1'b1)     begin bad++; $display("FAIL rd_rready: got %b want 1", axi_rready); end
        total++; if (axi_bready !== 1'b0)     begin bad++; $display("FAIL rd_bready: got %b want 0", axi_bready); end
        tick();
        total++; if (axi_arvalid !== 1'b0)    begin bad++; $display("FAIL rd_ardrop: got %b want 0", axi_arvalid); end
        axi_rvalid = 1'b1;
        axi_rdata  = 32'h1234_5678;
        axi_rresp  = 2'b10;
        tick();
        axi_rvalid = 1'b0;
        total++; if (core_rvalid !== 1'b1)        begin bad++; $display("FAIL rd_rvalid: got %b want 1", core_rvalid); end
        total++; if (core_rdata !== 32'h12345678) begin bad++; $display("FAIL rd_rdata: got %h want 12345678", core_rdata); end
        total++; if (core_err !== 1'b1)           begin bad++; $display("FAIL rd_err: got %b want 1", core_err); end
        tick();
        total++; if (core_rvalid !== 1'b0)        begin bad++; $display("FAIL rd_rvalid_pulse: got %b want 0", core_rvalid); end
        $display("txn read addr=00002004 data=12345678 err=1");
    endtask

    task automatic test_burst();
        axi_arready = 1'b1;
        axi_rresp   = 2'b00;
        for (int i = 0; i < 4; i++) begin
            core_req  = 1'b1;
            core_we   = 1'b0;
            core_addr = 32'h3000 + 4 * i;
            #1;
            total++; if (core_gnt !== 1'b1) begin bad++; $display("FAIL burst_gnt%0d: got %b want 1", i, core_gnt); end
            tick();
        end
        total++; if (outstanding !== 3'd4) begin bad++; $display("FAIL burst_count: got %0d want 4", outstanding); end
        core_addr = 32'h3010;
        #1;
        total++; if (core_gnt !== 1'b0) begin bad++; $display("FAIL burst_full_gnt: got %b want 0", core_gnt); end
        tick();
        total++; if (core_gnt !== 1'b0)    begin bad++; $display("FAIL burst_full_gnt2: got %b want 0", core_gnt); end
        total++; if (axi_arvalid !== 1'b0) begin bad++; $display("FAIL burst_ar_idle: got %b want 0", axi_arvalid); end
        axi_rvalid = 1'b1;
        axi_rdata  = 32'hA0;
        #1;
        total++; if (axi_rready !== 1'b1) begin bad++; $display("FAIL burst_rready: got %b want 1", axi_rready); end
        total++; if (core_gnt !== 1'b1)   begin bad++; $display("FAIL burst_gnt_on_pop: got %b want 1", core_gnt); end
        tick();
        core_req = 1'b0;
        total++; if (core_rvalid !== 1'b1)   begin bad++; $display("FAIL burst_rv0: got %b want 1", core_rvalid); end
        total++; if (core_rdata !== 32'hA0)  begin bad++; $display("FAIL burst_rd0: got %h want a0", core_rdata); end
        total++; if (outstanding !== 3'd4)   begin bad++; $display("FAIL burst_count_pp: got %0d want 4", outstanding); end
        total++; if (axi_araddr !== 32'h3010) begin bad++; $display("FAIL burst_araddr5: got %h want 00003010", axi_araddr); end
        for (int j = 1; j < 5; j++) begin
            axi_rdata = 32'hA0 + j;
            tick();
            total++; if (core_rvalid !== 1'b1)       begin bad++; $display("FAIL burst_rv%0d: got %b want 1", j, core_rvalid); end
            total++; if (core_rdata !== 32'hA0 + j)  begin bad++; $display("FAIL burst_rd%0d: got %h want %h", j, core_rdata, 32'hA0 + j); end
        end
        axi_rvalid = 1'b0;
        tick();
        total++; if (core_rvalid !== 1'b0) begin bad++; $display("FAIL burst_end_rv: got %b want 0", core_rvalid); end
        total++; if (outstanding !== 3'd0) begin bad++; $display("FAIL burst_end_count: got %0d want 0", outstanding); end
        $display("txn burst 5 reads from 00003000");
    endtask

    task automatic test_reorder();
        axi_awready = 1'b1;
        axi_wready  = 1'b1;
        axi_arready = 1'b1;
        core_req    = 1'b1;
        core_we     = 1'b1;
        core_addr   = 32'h4000;
        core_wdata  = 32'h1111_2222;
        core_be     = 4'hF;
        #1;
        total++; if (core_gnt !== 1'b1) begin bad++; $display("FAIL ro_wgnt: got %b want 1", core_gnt); end
        tick();
        core_we   = 1'b0;
        core_addr = 32'h4008;
        #1;
        total++; if (core_gnt !== 1'b1) begin bad++; $display("FAIL ro_rgnt: got %b want 1", core_gnt); end
        tick();
        core_req   = 1'b0;
        axi_rvalid = 1'b1;
        axi_rdata  = 32'h55;
        axi_rresp  = 2'b00;
        #1;
        total++; if (axi_rready !== 1'b0) begin bad++; $display("FAIL ro_rready_hold: got %b want 0", axi_rready); end
        total++; if (axi_bready !== 1'b1) begin bad++; $display("FAIL ro_bready: got %b want 1", axi_bready); end
        tick();
        total++; if (core_rvalid !== 1'b0) begin bad++; $display("FAIL ro_no_early_r: got %b want 0", core_rvalid); end
        axi_bvalid = 1'b1;
        axi_bresp  = 2'b00;
        #1;
        total++; if (axi_rready !== 1'b0) begin bad++; $display("FAIL ro_rready_hold2: got %b want 0", axi_rready); end
        tick();
        axi_bvalid = 1'b0;
        total++; if (core_rvalid !== 1'b1) begin bad++; $display("FAIL ro_b_rv: got %b want 1", core_rvalid); end
        total++; if (core_rdata !== 32'h0) begin bad++; $display("FAIL ro_b_rdata: got %h want 0", core_rdata); end
        #1;
        total++; if (axi_rready !== 1'b1) begin bad++; $display("FAIL ro_rready_now: got %b want 1", axi_rready); end
        tick();
        axi_rvalid = 1'b0;
        total++; if (core_rvalid !== 1'b1)  begin bad++; $display("FAIL ro_r_rv: got %b want 1", core_rvalid); end
        total++; if (core_rdata !== 32'h55) begin bad++; $display("FAIL ro_r_rdata: got %h want 55", core_rdata); end
        tick();
        total++; if (core_rvalid !== 1'b0)  begin bad++; $display("FAIL ro_end_rv: got %b want 0", core_rvalid); end
        axi_awready = 1'b0;
        axi_wready  = 1'b0;
        $display("txn reorder write 00004000 then read 00004008");
    endtask

    task automatic test_channel_skew();
        axi_awready = 1'b0;
        axi_wready  = 1'b1;
        core_req    = 1'b1;
        core_we     = 1'b1;
        core_addr   = 32'h5000;
        core_wdata  = 32'hCAFE_F00D;
        core_be     = 4'h3;
        #1;
        total++; if (core_gnt !== 1'b1) begin bad++; $display("FAIL sk_gnt1: got %b want 1", core_gnt); end
        tick();
        core_req = 1'b0;
        total++; if (axi_wstrb !== 4'h3) begin bad++; $display("FAIL sk_wstrb: got %h want 3", axi_wstrb); end
        tick();
        total++; if (axi_wvalid !== 1'b0)      begin bad++; $display("FAIL sk_wdrop: got %b want 0", axi_wvalid); end
        total++; if (axi_awvalid !== 1'b1)     begin bad++; $display("FAIL sk_awhold: got %b want 1", axi_awvalid); end
        core_req   = 1'b1;
        core_addr  = 32'h5100;
        core_wdata = 32'h0000_0001;
        core_be    = 4'hF;
        #1;
        total++; if (core_gnt !== 1'b0) begin bad++; $display("FAIL sk_gnt_blocked: got %b want 0", core_gnt); end
        tick();
        total++; if (axi_awaddr !== 32'h5000) begin bad++; $display("FAIL sk_awaddr_stable: got %h want 00005000", axi_awaddr); end
        total++; if (core_gnt !== 1'b0)       begin bad++; $display("FAIL sk_gnt_blocked2: got %b want 0", core_gnt); end
        axi_awready = 1'b1;
        #1;
        total++; if (core_gnt !== 1'b1) begin bad++; $display("FAIL sk_gnt2: got %b want 1", core_gnt); end
        tick();
        core_req = 1'b0;
        total++; if (axi_awaddr !== 32'h5100) begin bad++; $display("FAIL sk_awaddr2: got %h want 00005100", axi_awaddr); end
        total++; if (axi_wdata !== 32'h1)     begin bad++; $display("FAIL sk_wdata2: got %h want 1", axi_wdata); end
        total++; if (axi_wvalid !== 1'b1)     begin bad++; $display("FAIL sk_wvalid2: got %b want 1", axi_wvalid); end
        total++; if (outstanding !== 3'd2)    begin bad++; $display("FAIL sk_count: got %0d want 2", outstanding); end
        tick();
        total++; if (axi_awvalid !== 1'b0) begin bad++; $display("FAIL sk_awdone: got %b want 0", axi_awvalid); end
        axi_bvalid = 1'b1;
        axi_bresp  = 2'b10;
        tick();
        axi_bresp = 2'b00;
        total++; if (core_rvalid !== 1'b1) begin bad++; $display("FAIL sk_rv1: got %b want 1", core_rvalid); end
        total++; if (core_err !== 1'b1)    begin bad++; $display("FAIL sk_err1: got %b want 1", core_err); end
        tick();
        axi_bvalid = 1'b0;
        total++; if (core_rvalid !== 1'b1) begin bad++; $display("FAIL sk_rv2: got %b want 1", core_rvalid); end
        total++; if (core_err !== 1'b0)    begin bad++; $display("FAIL sk_err2: got %b want 0", core_err); end
        tick();
        total++; if (core_rvalid !== 1'b0) begin bad++; $display("FAIL sk_end_rv: got %b want 0", core_rvalid); end
        axi_awready = 1'b0;
        axi_wready  = 1'b0;
        $display("txn skewed writes 00005000 and 00005100");
    endtask

    task automatic test_reset_mid();
        axi_arready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            core_req  = 1'b1;
            core_we   = 1'b0;
            core_addr = 32'h6000 + 4 * i;
            #1;
            total++; if (core_gnt !== 1'b1) begin bad++; $display("FAIL rm_gnt%0d: got %b want 1", i, core_gnt); end
            tick();
        end
        core_req = 1'b0;
        total++; if (outstanding !== 3'd3) begin bad++; $display("FAIL rm_count3: got %0d want 3", outstanding); end
        rst        = 1'b1;
        axi_rvalid = 1'b1;
        axi_rdata  = 32'hBAD;
        #1;
        total++; if (axi_arvalid !== 1'b0) begin bad++; $display("FAIL rm_arvalid: got %b want 0", axi_arvalid); end
        total++; if (axi_rready !== 1'b0)  begin bad++; $display("FAIL rm_rready: got %b want 0", axi_rready); end
        total++; if (outstanding !== 3'd0) begin bad++; $display("FAIL rm_count0: got %0d want 0", outstanding); end
        tick();
        tick();
        total++; if (core_rvalid !== 1'b0) begin bad++; $display("FAIL rm_stale_rv: got %b want 0", core_rvalid); end
        axi_rvalid = 1'b0;
        rst        = 1'b0;
        core_req   = 1'b1;
        core_we    = 1'b0;
        core_addr  = 32'h7000;
        #1;
        total++; if (core_gnt !== 1'b1)    begin bad++; $display("FAIL rm_new_gnt: got %b want 1", core_gnt); end
        total++; if (axi_rready !== 1'b0)  begin bad++; $display("FAIL rm_rready_after: got %b want 0", axi_rready); end
        tick();
        core_req = 1'b0;
        total++; if (axi_arvalid !== 1'b1)    begin bad++; $display("FAIL rm_new_arvalid: got %b want 1", axi_arvalid); end
        total++; if (axi_araddr !== 32'h7000) begin bad++; $display("FAIL rm_new_araddr: got %h want 00007000", axi_araddr); end
        total++; if (core_rvalid !== 1'b0)    begin bad++; $display("FAIL rm_stale_rv2: got %b want 0", core_rvalid); end
        tick();
        axi_rvalid = 1'b1;
        axi_rdata  = 32'h77;
        axi_rresp  = 2'b00;
        tick();
        axi_rvalid = 1'b0;
        total++; if (core_rvalid !== 1'b1)  begin bad++; $display("FAIL rm_rv: got %b want 1", core_rvalid); end
        total++; if (core_rdata !== 32'h77) begin bad++; $display("FAIL rm_rdata: got %h want 77", core_rdata); end
        tick();
        $display("txn reset mid-burst then read 00007000");
    endtask

    initial begin
        rst         = 1'b1;
        core_req    = 1'b0;
        core_we     = 1'b0;
        core_be     = 4'h0;
        core_addr   = 32'h0;
        core_wdata  = 32'h0;
        axi_awready = 1'b0;
        axi_wready  = 1'b0;
        axi_bvalid  = 1'b0;
        axi_bresp   = 2'b00;
        axi_arready = 1'b0;
        axi_rvalid  = 1'b0;
        axi_rdata   = 32'h0;
        axi_rresp   = 2'b00;

        test_reset();
        test_single_write();
        test_single_read();
        test_burst();
        test_reorder();
        test_channel_skew();
        test_reset_mid();

        // 1 write + 1 read + 5 burst + 2 reorder + 2 skew + 1 after reset
        total++;
        if (rvalid_pulses !== 12) begin
            bad++;
            $display("FAIL rvalid_total: got %0d want 12", rvalid_pulses);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
